// File: rtl/latched_demux.sv
// latched_demux: registered one-to-N word demultiplexer with held slots.
// Manual mode routes by a latched select; auto mode deinterleaves a stream.
module latched_demux #(
    parameter int WIDTH     = 8,
    parameter int N_OUTPUTS = 3,
    parameter int SEL_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         clken,
    input  logic [SEL_WIDTH-1:0]         sel,
    input  logic                         auto,
    input  logic [WIDTH-1:0]             in,
    input  logic                         in_valid,
    input  logic                         in_sync,
    output logic [N_OUTPUTS*WIDTH-1:0]   out,
    output logic [N_OUTPUTS-1:0]         out_valid,
    output logic                         frame_done,
    output logic                         sel_err
);

    // Slot count needs one extra bit when N_OUTPUTS == 2**SEL_WIDTH.
    localparam logic [SEL_WIDTH:0]   NSLOT = (SEL_WIDTH+1)'(N_OUTPUTS);
    localparam logic [SEL_WIDTH-1:0] LAST  = SEL_WIDTH'(N_OUTPUTS - 1);

    logic [SEL_WIDTH-1:0] sel_reg;
    logic [SEL_WIDTH-1:0] cursor;
    logic [SEL_WIDTH-1:0] cursor_nxt;
    logic [SEL_WIDTH-1:0] wslot;
    logic [N_OUTPUTS-1:0] wen;
    logic                 sel_ok;

    assign sel_ok = ({1'b0, sel} < NSLOT);

    // Pick the slot for this cycle's word from pre-edge register state.
    always_comb begin
        wslot = sel_reg;
        if (auto) begin
            if (in_sync) begin
                wslot = '0;
            end else begin
                wslot = cursor;
            end
        end
    end

    // One-hot write enable for the addressed slot.
    always_comb begin
        wen = '0;
        for (int k = 0; k < N_OUTPUTS; k++) begin
            wen[k] = in_valid && (wslot == SEL_WIDTH'(k));
        end
    end

    // Cursor follows the latched select in manual mode, else advances.
    always_comb begin
        cursor_nxt = cursor;
        if (!auto) begin
            cursor_nxt = sel_reg;
        end else if (clken && sel_ok) begin
            cursor_nxt = sel;
        end else if (in_valid && in_sync) begin
            cursor_nxt = SEL_WIDTH'(1);
        end else if (in_valid) begin
            if (wslot == LAST) begin
                cursor_nxt = '0;
            end else begin
                cursor_nxt = wslot + SEL_WIDTH'(1);
            end
        end
    end

    // Select latch and cursor registers; illegal selects are dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel_reg <= '0;
            cursor  <= '0;
        end else begin
            if (clken && sel_ok) begin
                sel_reg <= sel;
            end
            cursor <= cursor_nxt;
        end
    end

    // Held output slots; only the addressed slot is overwritten.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out <= '0;
        end else begin
            for (int k = 0; k < N_OUTPUTS; k++) begin
                if (wen[k]) begin
                    out[k*WIDTH +: WIDTH] <= in;
                end
            end
        end
    end

    // One-cycle strobes: write, end of auto frame, illegal select.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid  <= '0;
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            out_valid  <= wen;
            frame_done <= auto && in_valid && (wslot == LAST);
            sel_err    <= clken && !sel_ok;
        end
    end

endmodule

// File: doc/latched_demux.md
# latched_demux

Registered one-to-N word demultiplexer that writes an input word into one of `N_OUTPUTS` held output slots. It is the distribution-side counterpart of the latched input selector in the same core library. In manual mode, the target slot is latched from `sel` under `clken`. In auto mode, an internal cursor deinterleaves a round-robin word stream with frame-sync support. Each slot holds its last written value until overwritten and signals each write with a one-cycle strobe.

## Interface
- `WIDTH`, 8, word width in bits
- `N_OUTPUTS`, 3, number of output slots (2..2^SEL_WIDTH)
- `SEL_WIDTH`, 2, width of slot index
- `clk`  in  1  single clock; all logic is rising-edge
- `resetn`  in  1  synchronous, active-low reset
- `clken`  in  1  latch `sel` into the select register (manual) or the cursor (auto)
- `sel`  in  SEL_WIDTH  requested slot index
- `auto`  in  1  0 = manual routing, 1 = round-robin cursor routing
- `in`  in  WIDTH  input word
- `in_valid`  in  1  `in` is written this cycle
- `in_sync`  in  1  qualified by `in_valid`; the current word is slot 0 of a new frame (auto only)
- `out`  out  N_OUTPUTS*WIDTH  held slots; slot k occupies bits [k*WIDTH +: WIDTH]
- `out_valid`  out  N_OUTPUTS  one-cycle write strobe per slot
- `frame_done`  out  1  one-cycle pulse when slot N_OUTPUTS-1 is written in auto mode
- `sel_err`  out  1  one-cycle pulse when `clken`=1 with `sel` >= N_OUTPUTS

## Operation
- Registers:
  - `sel_reg` (SEL_WIDTH bits)
  - `cursor` (SEL_WIDTH bits)
  - `out` slots
  - `out_valid`, `frame_done`, `sel_err`
- Reset (`resetn`=0 at a clock edge): all of the above are cleared to 0, regardless of the other inputs. Reset asserted mid-frame discards cursor position. The next auto frame starts at slot 0 unless resynced.
- Select latch:
  - If `clken`=1 and `sel` < N_OUTPUTS, then `sel_reg` <= `sel`.
  - If `sel` >= N_OUTPUTS, `sel_reg` holds its value and `sel_err` pulses.
- Write slot:
  - Manual mode: `wslot` = `sel_reg`.
  - Auto mode, `in_sync`=1: `wslot` = 0.
  - Auto mode otherwise: `wslot` = `cursor`.
  - The write uses register values from before the edge. A `clken` in the same cycle affects only the next word.
- On `in_valid`=1: slot `wslot` <= `in` and `out_valid[wslot]` <= 1. All other slots hold, and their strobes are 0.
- Cursor update, highest priority first:
  1. `auto`=0: `cursor` <= `sel_reg`. Entering auto mode therefore starts at the last latched slot.
  2. `clken`=1 with a valid `sel`: `cursor` <= `sel`.
  3. `in_valid` with `in_sync`: `cursor` <= 1 (or 0 when N_OUTPUTS=1 is not allowed; N_OUTPUTS >= 2).
  4. `in_valid`: `cursor` <= `wslot`+1, or 0 if `wslot` = N_OUTPUTS-1. This is the wrap.
  5. Otherwise: hold.
- `frame_done` <= `auto` & `in_valid` & (`wslot` = N_OUTPUTS-1). It coincides with the last slot's `out_valid`.
- `in_sync` is ignored in manual mode.
- `clken`=0 with `in_valid`=0 leaves all state unchanged. Strobes return to 0.

## Timing
- Latency is 1 cycle. A word accepted at edge n is visible on `out` and `out_valid` after edge n. `frame_done` appears in the same cycle as that `out_valid`.
- A `clken` latch at edge n steers words accepted at edge n+1 onward.
- Back-to-back `in_valid` every cycle is supported at full rate, with no stall and no backpressure.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Wrap-around: with `auto`=1 and N_OUTPUTS=3, successive words go to slots 0,1,2,0,...
- A sync during a frame truncates it. No `frame_done` pulse is emitted for the truncated frame.

## Test plan
- **Reset:** hold `resetn`=0 for 5 cycles with `in_valid`=1 and `in`=8'hFF. Required: `out`=0, `out_valid`=0, `frame_done`=0 throughout.
- **Manual latch:** `clken`=0 and `sel`=1, then write `in`=8'hA5. Required: slot 0=8'hA5 and `out_valid`=3'b001. Next, pulse `clken` with `sel`=2, then write 8'h3C. Required: slot 2=8'h3C, slot 0 still 8'hA5, `out_valid`=3'b100, one cycle after acceptance.
- **Illegal select:** `clken`=1 with `sel`=3. Required: `sel_err` pulses once and `sel_reg` is unchanged. A following write of 8'h11 lands in the previously latched slot.
- **Auto stream:**
  - Setup: `auto`=1 with `in_sync` on the first word. Stream 8'h01..8'h06 on consecutive cycles.
  - Strobes: `out_valid` sequence is 001,010,100,001,010,100.
  - Frame pulses: `frame_done` pulses with words 8'h03 and 8'h06.
  - Final slots: {8'h06, 8'h05, 8'h04}.
- **Mid-frame resync:**
  - Stimulus: in auto mode, write 2 words, then send `in_sync` with 8'h77.
  - Required: 8'h77 lands in slot 0 and the cursor becomes 1. No `frame_done` pulse is emitted for the truncated frame.
- **Simultaneous clken and write:**
  - Stimulus: in auto mode with `cursor`=1, assert `clken` with `sel`=0 together with `in_valid` and 8'h9A.
  - Required: 8'h9A lands in slot 1. The next word lands in slot 0.
